// File: rtl/servo_pwm_multi.sv
// ---------------------------------------------------------------------------
// servo_pwm_multi
//   N-channel servo PWM generator. It has its own tick prescaler and frame
//   counter. Incoming position words are clamped to the servo range and held
//   as pending values. Pending values become active only at a frame boundary,
//   so a pulse that has already started is never shortened or lengthened.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low (0 = reset asserted)
//   en           run enable; low holds prescaler/frame counter at 0, pwm low
//   pos_data     packed positions, channel i at [i*POS_W +: POS_W]
//   pos_valid    per-channel load strobe (one clk per word)
//   pwm          servo pulse outputs (registered)
//   frame_start  high during the boundary clk of every frame
//   clamp_flag   sticky: channel received a position above SPAN_TICKS
//   pend         channel holds a pending value not yet applied
// ---------------------------------------------------------------------------
module servo_pwm_multi #(
    parameter int N_CH         = 2,
    parameter int POS_W        = 10,
    parameter int TICK_DIV     = 100,
    parameter int PERIOD_TICKS = 3000,
    parameter int MIN_TICKS    = 1000,
    parameter int SPAN_TICKS   = 1000,
    parameter int RST_POS      = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH*POS_W-1:0]   pos_data,
    input  logic [N_CH-1:0]         pos_valid,
    output logic [N_CH-1:0]         pwm,
    output logic                    frame_start,
    output logic [N_CH-1:0]         clamp_flag,
    output logic [N_CH-1:0]         pend
);

    // One extra bit over the frame counter so MIN_TICKS + position can never
    // wrap in the width comparison.
    localparam int CW = $clog2(PERIOD_TICKS) + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Position words are compared against SPAN_TICKS at a width that holds both.
    localparam int XW = (POS_W > CW) ? POS_W : CW;

    logic [PW-1:0] presc_reg;
    logic [CW-1:0] cnt_reg;
    logic          tick_last;
    logic          boundary;

    assign tick_last = (presc_reg == PW'(TICK_DIV - 1));
    assign boundary  = en && (presc_reg == '0) && (cnt_reg == '0);

    // Gated with rst so frame_start reads low while reset is held, even
    // though the counters already sit at the boundary position.
    assign frame_start = rst && boundary;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else if (!en) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else if (tick_last) begin
            presc_reg <= '0;
            cnt_reg   <= (cnt_reg == CW'(PERIOD_TICKS - 1)) ? '0 : cnt_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [XW-1:0] pos_ext;
            logic          over;
            logic [CW-1:0] clamped;
            logic [CW-1:0] pending_reg;
            logic [CW-1:0] active_reg;
            logic [CW-1:0] active_eff;
            logic          pend_reg;
            logic          clamp_reg;
            logic          pwm_reg;

            assign pos_ext = XW'(pos_data[gi*POS_W +: POS_W]);
            assign over    = (pos_ext > XW'(SPAN_TICKS));
            assign clamped = over ? CW'(SPAN_TICKS) : CW'(pos_ext);

            // In the boundary clk the width being started is the one about to
            // be transferred, so the first pulse clk already uses it.
            assign active_eff = (boundary && pend_reg) ? pending_reg : active_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pending_reg <= CW'(RST_POS);
                    active_reg  <= CW'(RST_POS);
                    pend_reg    <= 1'b0;
                    clamp_reg   <= 1'b0;
                    pwm_reg     <= 1'b0;
                end else begin
                    if (boundary && pend_reg) begin
                        active_reg <= pending_reg;
                    end
                    // A load in the boundary clk wins over the clear: the old
                    // pending value has just been transferred, the new word
                    // waits for the next frame.
                    if (pos_valid[gi]) begin
                        pending_reg <= clamped;
                        pend_reg    <= 1'b1;
                        if (over) begin
                            clamp_reg <= 1'b1;
                        end
                    end else if (boundary) begin
                        pend_reg <= 1'b0;
                    end
                    pwm_reg <= en && (cnt_reg < (CW'(MIN_TICKS) + active_eff));
                end
            end

            assign pwm[gi]        = pwm_reg;
            assign pend[gi]       = pend_reg;
            assign clamp_flag[gi] = clamp_reg;
        end
    endgenerate

endmodule
